// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: widths, opcodes and FSM encodings.
package pipe_ctrl_pkg;

  localparam int unsigned WORD_ADDR    = 32;
  localparam int unsigned REGS_ADDR    = 5;
  localparam int unsigned RISCV_OPCODE = 7;

  localparam logic [RISCV_OPCODE-1:0] INS_TYPE_L = 7'b0000011;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    CU_RUN      = 2'd0,
    CU_FLUSH    = 2'd1,
    CU_MEM_WAIT = 2'd2
  } cu_state_e;

  // IMEM_LAT is at most 3, so the flush counter never needs more than 2 bits.
  localparam int unsigned FLUSH_CNT_W = 2;

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hazard_det.sv
// Load-use hazard comparator between the load in ID/EX and the sources in IF/ID.
module hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic [RISCV_OPCODE-1:0] idex_opcode_i,
  input  logic [REGS_ADDR-1:0]    idex_rd_i,
  input  logic [REGS_ADDR-1:0]    ifid_rs1_i,
  input  logic [REGS_ADDR-1:0]    ifid_rs2_i,
  output logic                    hazard_o
);

  // x0 is never a real dependency, so a load targeting it cannot cause a stall.
  always_comb begin
    hazard_o = (idex_opcode_i == INS_TYPE_L) &&
               (idex_rd_i != '0) &&
               ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: resolves jumps, load-use hazards and multi-cycle memory
// accesses into PC redirect, per-stage stall/flush and EX write-back/memory enables.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_LAT    = 1,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex2cu_jump_en_i,
  input  logic [WORD_ADDR-1:0]    ex2cu_jump_addr_i,
  input  logic [RISCV_OPCODE-1:0] idex2cu_opcode_i,
  input  logic [REGS_ADDR-1:0]    idex2cu_rd_i,
  input  logic [REGS_ADDR-1:0]    ifid2cu_rs1_i,
  input  logic [REGS_ADDR-1:0]    ifid2cu_rs2_i,
  input  logic                    exmem2cu_mem_req_i,
  input  logic                    mem2cu_ack_i,
  output logic                    cu2pc_jump_en_o,
  output logic [WORD_ADDR-1:0]    cu2pc_jump_addr_o,
  output logic                    cu2pc_stall_o,
  output logic                    cu2ifid_stall_o,
  output logic                    cu2idex_stall_o,
  output logic                    cu2exmem_stall_o,
  output logic                    cu2ifid_flush_o,
  output logic                    cu2idex_flush_o,
  output logic                    cu2ex_wb_en_o,
  output logic                    cu2ex_mem_en_o,
  output logic                    cu2ex_mem_err_o
);

  localparam int unsigned TmoW = cnt_width(MEM_TIMEOUT);

  cu_state_e              state_q, state_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic [FLUSH_CNT_W-1:0] fl_q, fl_d;
  logic                   hazard;

  hazard_det u_hazard_det (
    .idex_opcode_i (idex2cu_opcode_i),
    .idex_rd_i     (idex2cu_rd_i),
    .ifid_rs1_i    (ifid2cu_rs1_i),
    .ifid_rs2_i    (ifid2cu_rs2_i),
    .hazard_o      (hazard)
  );

  // Next-state and zero-latency outputs from current state and inputs.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    fl_d    = fl_q;

    cu2pc_jump_en_o   = DISABLE;
    cu2pc_jump_addr_o = '0;
    cu2pc_stall_o     = DISABLE;
    cu2ifid_stall_o   = DISABLE;
    cu2idex_stall_o   = DISABLE;
    cu2exmem_stall_o  = DISABLE;
    cu2ifid_flush_o   = DISABLE;
    cu2idex_flush_o   = DISABLE;
    cu2ex_wb_en_o     = ENABLE;
    cu2ex_mem_en_o    = ENABLE;
    cu2ex_mem_err_o   = DISABLE;

    unique case (state_q)
      CU_RUN: begin
        if (exmem2cu_mem_req_i && !mem2cu_ack_i) begin
          cu2pc_stall_o    = ENABLE;
          cu2ifid_stall_o  = ENABLE;
          cu2idex_stall_o  = ENABLE;
          cu2exmem_stall_o = ENABLE;
          cu2ex_wb_en_o    = DISABLE;
          cu2ex_mem_en_o   = DISABLE;
          state_d          = CU_MEM_WAIT;
          tmo_d            = TmoW'(MEM_TIMEOUT - 1);
        end else if (ex2cu_jump_en_i) begin
          cu2pc_jump_en_o   = ENABLE;
          cu2pc_jump_addr_o = ex2cu_jump_addr_i;
          cu2ifid_flush_o   = ENABLE;
          cu2idex_flush_o   = ENABLE;
          // Slow instruction memory still has wrong-path fetches in flight.
          if (IMEM_LAT > 1) begin
            state_d = CU_FLUSH;
            fl_d    = FLUSH_CNT_W'(IMEM_LAT - 1);
          end
        end else if (hazard) begin
          cu2pc_stall_o   = ENABLE;
          cu2ifid_stall_o = ENABLE;
          cu2idex_flush_o = ENABLE;
        end
      end

      CU_FLUSH: begin
        cu2ifid_flush_o = ENABLE;
        if (fl_q <= FLUSH_CNT_W'(1)) begin
          state_d = CU_RUN;
          fl_d    = '0;
        end else begin
          fl_d = fl_q - FLUSH_CNT_W'(1);
        end
      end

      CU_MEM_WAIT: begin
        if (mem2cu_ack_i) begin
          // Stalls released and enables restored in the ack cycle itself.
          state_d = CU_RUN;
        end else if (tmo_q == '0) begin
          cu2ex_mem_err_o = ENABLE;
          cu2ifid_flush_o = ENABLE;
          cu2idex_flush_o = ENABLE;
          cu2ex_wb_en_o   = DISABLE;
          cu2ex_mem_en_o  = DISABLE;
          state_d         = CU_RUN;
        end else begin
          cu2pc_stall_o    = ENABLE;
          cu2ifid_stall_o  = ENABLE;
          cu2idex_stall_o  = ENABLE;
          cu2exmem_stall_o = ENABLE;
          cu2ex_wb_en_o    = DISABLE;
          cu2ex_mem_en_o   = DISABLE;
          tmo_d            = tmo_q - TmoW'(1);
        end
      end

      default: state_d = CU_RUN;
    endcase

    // Everything is quiet while reset is held, including the EX enables.
    if (!rst_n) begin
      cu2pc_jump_en_o   = DISABLE;
      cu2pc_jump_addr_o = '0;
      cu2pc_stall_o     = DISABLE;
      cu2ifid_stall_o   = DISABLE;
      cu2idex_stall_o   = DISABLE;
      cu2exmem_stall_o  = DISABLE;
      cu2ifid_flush_o   = DISABLE;
      cu2idex_flush_o   = DISABLE;
      cu2ex_wb_en_o     = DISABLE;
      cu2ex_mem_en_o    = DISABLE;
      cu2ex_mem_err_o   = DISABLE;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CU_RUN;
      tmo_q   <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      fl_q    <= fl_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios followed by random traffic,
// expected outputs from a behavioural model compared at the falling clock edge.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned ImemLat    = 2;
  localparam int unsigned MemTimeout = 4;
  localparam logic [6:0]  OpAlu      = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        mem_req = 1'b0;
  logic        mem_ack = 1'b0;

  logic        o_jen;
  logic [31:0] o_jaddr;
  logic        o_pc_st, o_ifid_st, o_idex_st, o_exmem_st;
  logic        o_ifid_fl, o_idex_fl, o_wb, o_mem, o_err;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .IMEM_LAT    (ImemLat),
    .MEM_TIMEOUT (MemTimeout)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ex2cu_jump_en_i    (jump_en),
    .ex2cu_jump_addr_i  (jump_addr),
    .idex2cu_opcode_i   (opcode),
    .idex2cu_rd_i       (rd),
    .ifid2cu_rs1_i      (rs1),
    .ifid2cu_rs2_i      (rs2),
    .exmem2cu_mem_req_i (mem_req),
    .mem2cu_ack_i       (mem_ack),
    .cu2pc_jump_en_o    (o_jen),
    .cu2pc_jump_addr_o  (o_jaddr),
    .cu2pc_stall_o      (o_pc_st),
    .cu2ifid_stall_o    (o_ifid_st),
    .cu2idex_stall_o    (o_idex_st),
    .cu2exmem_stall_o   (o_exmem_st),
    .cu2ifid_flush_o    (o_ifid_fl),
    .cu2idex_flush_o    (o_idex_fl),
    .cu2ex_wb_en_o      (o_wb),
    .cu2ex_mem_en_o     (o_mem),
    .cu2ex_mem_err_o    (o_err)
  );

  typedef struct packed {
    logic        jen;
    logic [31:0] addr;
    logic        pc_st;
    logic        ifid_st;
    logic        idex_st;
    logic        exmem_st;
    logic        ifid_fl;
    logic        idex_fl;
    logic        wb;
    logic        mem;
    logic        err;
  } outs_t;

  typedef struct {
    outs_t exp;
    int    cyc;
    string tag;
  } item_t;

  item_t sb_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;

  // Behavioural model: remaining post-jump flush cycles, and memory wait progress.
  int    flush_left = 0;
  bit    waiting = 1'b0;
  int    waited = 0;

  outs_t act;
  assign act = {o_jen, o_jaddr, o_pc_st, o_ifid_st, o_idex_st, o_exmem_st,
                o_ifid_fl, o_idex_fl, o_wb, o_mem, o_err};

  // Drive one cycle of inputs and queue the response the model expects.
  task automatic step(input string tag, input logic rn, input logic req, input logic ack,
                      input logic jmp, input logic [31:0] ja, input logic [6:0] op,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    outs_t e;
    item_t it;
    bit    hz;
    @(posedge clk);
    #1;
    rst_n = rn; mem_req = req; mem_ack = ack; jump_en = jmp; jump_addr = ja;
    opcode = op; rd = d; rs1 = s1; rs2 = s2;
    cyc++;
    e = '0;
    hz = (op == 7'b0000011) && (d != 0) && (d == s1 || d == s2);
    if (!rn) begin
      flush_left = 0;
      waiting = 1'b0;
      waited = 0;
    end else if (waiting) begin
      if (ack) begin
        e.wb = 1'b1; e.mem = 1'b1;
        waiting = 1'b0;
      end else if (waited + 1 == int'(MemTimeout)) begin
        e.err = 1'b1; e.ifid_fl = 1'b1; e.idex_fl = 1'b1;
        waiting = 1'b0;
      end else begin
        e.pc_st = 1'b1; e.ifid_st = 1'b1; e.idex_st = 1'b1; e.exmem_st = 1'b1;
        waited++;
      end
    end else if (flush_left > 0) begin
      e.ifid_fl = 1'b1; e.wb = 1'b1; e.mem = 1'b1;
      flush_left--;
    end else if (req && !ack) begin
      e.pc_st = 1'b1; e.ifid_st = 1'b1; e.idex_st = 1'b1; e.exmem_st = 1'b1;
      waiting = 1'b1;
      waited = 0;
    end else if (jmp) begin
      e.jen = 1'b1; e.addr = ja; e.ifid_fl = 1'b1; e.idex_fl = 1'b1;
      e.wb = 1'b1; e.mem = 1'b1;
      flush_left = int'(ImemLat) - 1;
    end else if (hz) begin
      e.pc_st = 1'b1; e.ifid_st = 1'b1; e.idex_fl = 1'b1; e.wb = 1'b1; e.mem = 1'b1;
    end else begin
      e.wb = 1'b1; e.mem = 1'b1;
    end
    it.exp = e;
    it.cyc = cyc;
    it.tag = tag;
    sb_q.push_back(it);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  item_t mon_it;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_it = sb_q.pop_front();
      checks++;
      if (act !== mon_it.exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", mon_it.tag, mon_it.cyc, act,
                 mon_it.exp);
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    // Reset held: every output, enables included, must be 0.
    for (int i = 0; i < 3; i++) step("reset", 0, 0, 0, 1, 32'h55, 7'b0000011, 5, 5, 5);

    // Back-to-back ALU ops.
    for (int i = 0; i < 4; i++) step("alu", 1, 0, 0, 0, 0, OpAlu, 5'(i + 1), 5'(i + 2), 3);

    // Load-use: lw x5 then add x6,x5,x7; bubble follows; rd=x0 never stalls.
    step("lduse", 1, 0, 0, 0, 0, 7'b0000011, 5, 5, 7);
    step("lduse_bubble", 1, 0, 0, 0, 0, 7'b0000000, 0, 5, 7);
    step("lduse_rs2", 1, 0, 0, 0, 0, 7'b0000011, 9, 1, 9);
    step("lduse_x0", 1, 0, 0, 0, 0, 7'b0000011, 0, 0, 0);

    // Jump to 0x100 with two-cycle instruction memory.
    step("jump", 1, 0, 0, 1, 32'h100, OpAlu, 1, 2, 3);
    step("jump_flush", 1, 0, 0, 1, 32'h200, 7'b0000011, 4, 4, 4);
    step("jump_after", 1, 0, 0, 0, 0, OpAlu, 1, 2, 3);

    // Memory ack on the third cycle after the request, jump presented meanwhile.
    step("mem_req", 1, 1, 0, 0, 0, OpAlu, 0, 0, 0);
    step("mem_wait1", 1, 1, 0, 1, 32'h340, OpAlu, 0, 0, 0);
    step("mem_wait2", 1, 1, 0, 1, 32'h340, OpAlu, 0, 0, 0);
    step("mem_ack", 1, 1, 1, 1, 32'h340, OpAlu, 0, 0, 0);
    step("mem_jump", 1, 0, 0, 1, 32'h340, OpAlu, 0, 0, 0);
    step("mem_jflush", 1, 0, 0, 0, 0, OpAlu, 0, 0, 0);

    // Same-cycle ack causes no stall.
    step("mem_fast", 1, 1, 1, 0, 0, OpAlu, 0, 0, 0);

    // Timeout: no ack, error pulse on the fourth wait cycle.
    step("tmo_req", 1, 1, 0, 0, 0, OpAlu, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("tmo_wait", 1, 1, 0, 0, 0, OpAlu, 0, 0, 0);
    step("tmo_after", 1, 0, 0, 0, 0, OpAlu, 0, 0, 0);

    // Reset dropped mid-wait: outputs zero at once, clean RUN afterwards.
    step("rst_req", 1, 1, 0, 0, 0, OpAlu, 0, 0, 0);
    step("rst_wait", 1, 1, 0, 0, 0, OpAlu, 0, 0, 0);
    step("rst_mid", 0, 1, 0, 0, 0, OpAlu, 0, 0, 0);
    step("rst_mid", 0, 1, 0, 0, 0, OpAlu, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("rst_after", 1, 0, 0, 0, 0, OpAlu, 0, 0, 0);

    // Random traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      tgt = $urandom;
      step("random", logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 5) == 0),
           logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 6) == 0), tgt,
           ($urandom_range(0, 1) != 0) ? 7'b0000011 : OpAlu,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core; it sequences the execute stage and its neighbouring pipeline registers. It resolves three events: taken jumps/branches reported by EX, load-use hazards between ID/EX and IF/ID, and multi-cycle data-memory accesses from EX/MEM. From these it generates PC redirect, per-stage stall/flush, and the write-back and memory enables consumed by EX.

## Interface
- `IMEM_LAT`, default 1: instruction-memory read latency in cycles (1..3); sets the length of the IF/ID flush after a redirect.
- `MEM_TIMEOUT`, default 16: maximum cycles to wait for a data-memory ack before abandoning the access.
- `clk` in 1: core clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `ex2cu_jump_en_i` in 1: EX reports a taken branch or JAL.
- `ex2cu_jump_addr_i` in `WORD_ADDR`: redirect target.
- `idex2cu_opcode_i` in `RISCV_OPCODE`: opcode in ID/EX.
- `idex2cu_rd_i` in `REGS_ADDR`: rd in ID/EX.
- `ifid2cu_rs1_i`, `ifid2cu_rs2_i` in `REGS_ADDR`: source registers of the instruction in IF/ID.
- `exmem2cu_mem_req_i` in 1: EX/MEM holds a valid load/store.
- `mem2cu_ack_i` in 1: data memory completes the access this cycle.
- `cu2pc_jump_en_o` out 1: PC load strobe.
- `cu2pc_jump_addr_o` out `WORD_ADDR`: PC load value.
- `cu2pc_stall_o` out 1: hold PC.
- `cu2ifid_stall_o`, `cu2idex_stall_o`, `cu2exmem_stall_o` out 1: hold the named register.
- `cu2ifid_flush_o`, `cu2idex_flush_o` out 1: load a bubble into the named register.
- `cu2ex_wb_en_o` out 1: EX may assert register write-back.
- `cu2ex_mem_en_o` out 1: EX may issue a memory access.
- `cu2ex_mem_err_o` out 1: one-cycle pulse on memory timeout.

## Operation
- States: RUN, FLUSH, MEM_WAIT.
- RUN, priority from highest to lowest:
  - **Memory request.** If `exmem2cu_mem_req_i` is high and `mem2cu_ack_i` is low: assert all four stalls, drop `cu2ex_wb_en_o` and `cu2ex_mem_en_o`, go to MEM_WAIT, and load the timeout counter with `MEM_TIMEOUT-1`. A request acked in the same cycle causes no stall.
  - **Jump.** If `ex2cu_jump_en_i` is high: `cu2pc_jump_en_o`=1, `cu2pc_jump_addr_o`=`ex2cu_jump_addr_i`, and flush both IF/ID and ID/EX. If `IMEM_LAT`>1, go to FLUSH and load the flush counter with `IMEM_LAT-1`.
  - **Load-use hazard.** A hazard exists when `idex2cu_opcode_i`==`INS_TYPE_L`, `idex2cu_rd_i`≠0, and rd equals rs1 or rs2 of IF/ID. Response: stall PC and IF/ID, flush ID/EX, for one cycle. The hazard clears naturally once the bubble occupies ID/EX; no state change.
  - **Otherwise.** `cu2ex_wb_en_o`=1, `cu2ex_mem_en_o`=1, and every other output is 0.
- FLUSH: `cu2ifid_flush_o`=1 and the counter decrements. At 0, go to RUN. Jump and load-use inputs are ignored here; the stages they come from hold bubbles.
- MEM_WAIT: all stalls held.
  - On `mem2cu_ack_i`: release the stalls in the same cycle, re-enable wb/mem, go to RUN.
  - When the counter reaches 0 without an ack: pulse `cu2ex_mem_err_o`, flush IF/ID and ID/EX, go to RUN.
  - A jump asserted during MEM_WAIT is not taken. EX is held, so the jump is re-presented and taken in the first RUN cycle.
- `cu2pc_jump_addr_o` is 0 whenever `cu2pc_jump_en_o` is 0.

## Timing
- State and counters are registered. All outputs are combinational from the current state and inputs: zero-cycle response.
- Reset (`rst_n` low, asynchronous) forces:
  - state to RUN and both counters to 0;
  - every output to 0, including `cu2ex_wb_en_o` and `cu2ex_mem_en_o`, while `rst_n` is low.
- Release of reset takes effect on the first `clk` edge with `rst_n` high.
- Reset asserted during MEM_WAIT or FLUSH abandons the operation without an error pulse.
- Jump redirect latency: PC loads the target at the edge ending the cycle in which EX reports it. The total bubble count is 1+`IMEM_LAT`.
- Load-use penalty is exactly one bubble.
- Timeout counter width is clog2(`MEM_TIMEOUT`). The counter does not wrap; it saturates at 0.

## Structure
- In the shared defines header:
  - state encodings `CU_RUN`, `CU_FLUSH`, `CU_MEM_WAIT` (2 bits);
  - the existing `INS_TYPE_L`, `WORD_ADDR`, `REGS_ADDR`, `ENABLE`/`DISABLE`.
- One sub-module, `hazard_det`: purely combinational load-use comparison producing a single `hazard` bit. The FSM and counters stay in `pipe_ctrl`.

## Test plan
- **Back-to-back ALU ops, no hazards:** every stall/flush stays 0; wb_en and mem_en stay 1.
- **Load-use:** `lw x5` in ID/EX with `add x6,x5,x7` in IF/ID → one cycle of PC/IF/ID stall plus ID/EX flush, then normal flow. The same pattern with rd=x0 → no stall.
- **Jump, `IMEM_LAT`=2, target 0x100:** `cu2pc_jump_en_o`=1 with address 0x100 for one cycle, IF/ID flushed for 2 cycles total, ID/EX flushed for 1.
- **Memory ack after 3 cycles:** stalls held for exactly 3 cycles, released in the ack cycle; a jump asserted concurrently is taken in the first RUN cycle.
- **No ack, `MEM_TIMEOUT`=4:** `cu2ex_mem_err_o` pulses in the 4th wait cycle with both flushes, then RUN.
- **`rst_n` dropped mid-MEM_WAIT:** all outputs go to 0 immediately; after release the FSM is in RUN with no error pulse.
